// File: rtl/risc_v_decode_queue.sv
// rtl/risc_v_decode_queue.sv - instruction decode/dispatch queue between fetch and dispatch
package risc_v_decode_queue_pkg;
    typedef enum logic [1:0] {
        NON_VALID_RD_TAG = 2'd0,
        STORE            = 2'd1,
        BRANCH           = 2'd2,
        JUMP             = 2'd3
    } dispatch_type;
endpackage

module risc_v_decode_queue
    import risc_v_decode_queue_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  int PC_WIDTH = 32,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [2:0]          out_func3,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [6:0]          out_func7,
    output logic [31:0]         out_imm,
    output dispatch_type        out_dispatch_type,
    output logic                out_rd_valid,
    output logic                out_illegal,
    output logic [PTR_W:0]      count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]         instr_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;
    logic [31:0]      head;

    // Handshake: reset and flush both hold off fetch; the head is valid whenever occupied
    always_comb begin
        in_ready  = (count_q != FULL_CNT) && !flush && !rst;
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        count     = count_q;
    end

    // Next-state pointers and occupancy; flush wins over any push/pop in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
            else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Pointer/occupancy registers; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

    // Field extraction from the head slot
    always_comb begin
        head       = instr_mem[rd_ptr_q];
        out_pc     = pc_mem[rd_ptr_q];
        out_opcode = head[6:0];
        out_rd     = head[11:7];
        out_func3  = head[14:12];
        out_rs1    = head[19:15];
        out_rs2    = head[24:20];
        out_func7  = head[31:25];
    end

    // Opcode classification and immediate formation for the head entry
    always_comb begin
        out_dispatch_type = NON_VALID_RD_TAG;
        out_rd_valid      = 1'b0;
        out_illegal       = 1'b0;
        out_imm           = '0;
        case (head[6:0])
            OP_R: begin
                out_rd_valid = (head[11:7] != 5'd0);
            end
            OP_I, OP_LOAD: begin
                out_rd_valid = (head[11:7] != 5'd0);
                out_imm      = {{20{head[31]}}, head[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                out_rd_valid = (head[11:7] != 5'd0);
                out_imm      = {head[31:12], 12'b0};
            end
            OP_STORE: begin
                out_dispatch_type = STORE;
                out_imm           = {{20{head[31]}}, head[31:25], head[11:7]};
            end
            OP_BRANCH: begin
                out_dispatch_type = BRANCH;
                out_imm           = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
            end
            OP_JAL: begin
                out_dispatch_type = JUMP;
                out_rd_valid      = (head[11:7] != 5'd0);
                out_imm           = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
            end
            OP_JALR: begin
                out_dispatch_type = JUMP;
                out_rd_valid      = (head[11:7] != 5'd0);
                out_imm           = {{20{head[31]}}, head[31:20]};
            end
            default: begin
                out_illegal = 1'b1;
            end
        endcase
    end

    // Overflow and underflow must be impossible through the handshake
    assert property (@(posedge clk) disable iff (rst) !(in_valid && in_ready && count_q == FULL_CNT));
    assert property (@(posedge clk) disable iff (rst) !(out_ready && pop && count_q == '0));

endmodule

// File: doc/risc_v_decode_queue.md
Name: risc_v_decode_queue

Overview:
- Parametrised decode/dispatch-queue stage between fetch and the dispatch unit of the RISC-V core.
- Buffers up to DEPTH fetched instructions with their PCs and decodes the head entry into register fields, a dispatch class, an rd-write flag, a sign-extended immediate and an illegal-opcode flag.
- Uses valid/ready handshakes on both sides and supports a single-cycle flush on branch/jump redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PC_WIDTH, 32, width of the PC carried with each instruction.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all queued entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue accepts an instruction this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_WIDTH  PC of in_instr.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  dispatch consumes the head this cycle.
- out_pc  output  PC_WIDTH  PC of the head entry.
- out_opcode  output  7  head instr[6:0].
- out_rd  output  5  head instr[11:7].
- out_func3  output  3  head instr[14:12].
- out_rs1  output  5  head instr[19:15].
- out_rs2  output  5  head instr[24:20].
- out_func7  output  7  head instr[31:25].
- out_imm  output  32  sign-extended immediate for the head's format.
- out_dispatch_type  output  dispatch_type  class of the head entry.
- out_rd_valid  output  1  head writes a non-zero rd.
- out_illegal  output  1  head opcode is not supported.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: asynchronous on rst high. Clears wr_ptr, rd_ptr and count to 0. While reset is asserted: out_valid=0, in_ready=0. in_ready goes to 1 on the first cycle after rst deasserts. Storage contents are don't-care. Reset mid-operation drops all entries.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH) && !flush.
  - out_valid = (count != 0).
- Latency: an instruction pushed at edge N is visible at the head after edge N (1 cycle) when the queue was empty. There is no bypass path.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, in_ready=0, so push does not occur even if a pop occurs that cycle.
- Pointers: wrap modulo DEPTH. count = push − pop, bounded to 0..DEPTH.
- Flush: has priority over push and pop in the same cycle. It zeroes the pointers and count at the edge. An in_valid instruction in the flush cycle is dropped, since in_ready=0.
- Decode: combinational on the head entry only. All out_* decode outputs are driven from the head slot even when out_valid=0; their values are don't-care then.
- out_dispatch_type by opcode:
  - R 0110011, I 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111 -> NON_VALID_RD_TAG.
  - STORE 0100011 -> STORE.
  - BRANCH 1100011 -> BRANCH.
  - JAL 1101111, JALR 1100111 -> JUMP.
  - Any other opcode -> NON_VALID_RD_TAG with out_illegal=1.
- out_rd_valid = (opcode in {R, I, LOAD, LUI, AUIPC, JAL, JALR}) && (rd != 0). It is 0 for STORE, BRANCH and illegal opcodes.
- out_imm:
  - I/LOAD/JALR: sext(instr[31:20]).
  - STORE: sext({instr[31:25], instr[11:7]}).
  - BRANCH: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - LUI/AUIPC: {instr[31:12], 12'b0}.
  - JAL: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R and illegal: 0.
- No overflow or underflow is possible. Push when full and pop when empty are blocked by the handshake. Assertions must flag in_valid && in_ready while full, and out_ready-driven pop while empty.

Test Plan:
- Reset then single push of 0x00A00093 (addi x1,x0,10) at pc 0x100 -> next cycle: out_valid=1, out_rd=1, out_imm=0x0000000A, type NON_VALID_RD_TAG, out_rd_valid=1, out_pc=0x100, count=1.
- With out_ready=0, push 4 instructions (DEPTH=4) -> count=4, in_ready=0. A 5th in_valid is not accepted. Popping 4 returns them in push order with the correct PCs.
- Continuous push+pop for 10 cycles from count=2 -> count stays 2, pointers wrap, and outputs match a reference model in order.
- Decode sweep:
  - sw x2,-4(x1) = 0xFE20AE23 -> STORE, imm=0xFFFFFFFC, rd_valid=0.
  - beq x0,x0,-8 = 0xFE000CE3 -> BRANCH, imm=0xFFFFFFF8.
  - jal x1,+2048 = 0x001000EF -> JUMP, rd_valid=1, imm=0x00000800.
  - lui x5,0x12345 = 0x123452B7 -> imm=0x12345000.
  - opcode 0x7F -> out_illegal=1.
- Flush at count=3 with in_valid=1 the same cycle -> next cycle count=0, out_valid=0, and the flushing-cycle instruction is absent.
- Assert rst for one cycle at count=3 mid-stream -> out_valid=0 immediately (async) and count=0. After deassert, in_ready=1 and new pushes are accepted normally.
